// File: rtl/ew_source_switch.sv
// Registered N-way event-window source selector feeding the EW FIFO controller.
// Source changes are held off until the current event window has closed.
module ew_source_switch #(
  parameter int NSRC            = 4,
  parameter int SEL_BITS        = 2,
  parameter int DIGI_BITS       = 32,
  parameter int EVENT_SIZE_BITS = 10,
  parameter int SPILL_TAG_BITS  = 20,
  parameter int DEFAULT_SEL     = 0,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                              serdesclk,
  input  logic                              reset_serdesclk,
  input  logic [SEL_BITS-1:0]               req_sel,
  input  logic [NSRC-1:0]                   src_curr_ewfifo_wr,
  input  logic [NSRC-1:0]                   src_ew_done,
  input  logic [NSRC-1:0]                   src_ew_ovfl,
  input  logic [NSRC-1:0]                   src_ew_fifo_we,
  input  logic [NSRC-1:0]                   src_ew_tag_error,
  input  logic [NSRC-1:0]                   src_tag_sync_error,
  input  logic [NSRC*DIGI_BITS-1:0]         src_ew_fifo_data,
  input  logic [NSRC*EVENT_SIZE_BITS-1:0]   src_ew_size,
  input  logic [NSRC*SPILL_TAG_BITS-1:0]    src_ew_tag,
  input  logic                              axi_start_on_serdesclk,
  output logic                              curr_ewfifo_wr,
  output logic                              ew_done,
  output logic                              ew_ovfl,
  output logic                              ew_fifo_we,
  output logic                              ew_tag_error,
  output logic                              tag_sync_error,
  output logic [DIGI_BITS-1:0]              ew_fifo_data,
  output logic [EVENT_SIZE_BITS-1:0]        ew_size,
  output logic [SPILL_TAG_BITS-1:0]         ew_tag,
  output logic [NSRC-1:0]                   src_axi_start,
  output logic [SEL_BITS-1:0]               active_sel,
  output logic                              window_open,
  output logic                              switch_pending,
  output logic                              ew_timeout,
  output logic                              sel_error
);

  localparam int CNT_BITS = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_BITS:0]   NSRC_V   = (SEL_BITS + 1)'(NSRC);
  localparam logic [SEL_BITS-1:0] DEF_SEL  = SEL_BITS'(DEFAULT_SEL);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                     state, state_next;
  logic [CNT_BITS-1:0]        cnt, cnt_next;
  logic                       timeout_next;
  logic                       req_valid;
  logic [SEL_BITS-1:0]        next_sel;

  logic                       mux_curr_wr, mux_done, mux_ovfl, mux_we;
  logic                       mux_tag_error, mux_sync_error;
  logic [DIGI_BITS-1:0]       mux_data;
  logic [EVENT_SIZE_BITS-1:0] mux_size;
  logic [SPILL_TAG_BITS-1:0]  mux_tag;
  logic [NSRC-1:0]            start_vec;

  // A new request is only honoured while no window is open.
  always_comb begin
    req_valid = ({1'b0, req_sel} < NSRC_V);
    next_sel  = (state == IDLE && req_valid) ? req_sel : active_sel;
  end

  always_comb begin
    mux_curr_wr    = 1'b0;
    mux_done       = 1'b0;
    mux_ovfl       = 1'b0;
    mux_we         = 1'b0;
    mux_tag_error  = 1'b0;
    mux_sync_error = 1'b0;
    mux_data       = '0;
    mux_size       = '0;
    mux_tag        = '0;
    start_vec      = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (SEL_BITS'(i) == next_sel) begin
        mux_curr_wr    = src_curr_ewfifo_wr[i];
        mux_done       = src_ew_done[i];
        mux_ovfl       = src_ew_ovfl[i];
        mux_we         = src_ew_fifo_we[i];
        mux_tag_error  = src_ew_tag_error[i];
        mux_sync_error = src_tag_sync_error[i];
        mux_data       = src_ew_fifo_data[i*DIGI_BITS +: DIGI_BITS];
        mux_size       = src_ew_size[i*EVENT_SIZE_BITS +: EVENT_SIZE_BITS];
        mux_tag        = src_ew_tag[i*SPILL_TAG_BITS +: SPILL_TAG_BITS];
        start_vec[i]   = axi_start_on_serdesclk;
      end
    end
  end

  // Window FSM; a restart inside a window wins over a done in the same cycle.
  always_comb begin
    state_next   = state;
    cnt_next     = '0;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        if (axi_start_on_serdesclk) state_next = BUSY;
      end
      BUSY: begin
        if (axi_start_on_serdesclk) begin
          state_next = BUSY;
        end else if (mux_done) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_BITS'(1);
        end
      end
    endcase
  end

  always_ff @(posedge serdesclk) begin
    if (reset_serdesclk) begin
      state          <= IDLE;
      cnt            <= '0;
      active_sel     <= DEF_SEL;
      curr_ewfifo_wr <= 1'b0;
      ew_done        <= 1'b0;
      ew_ovfl        <= 1'b0;
      ew_fifo_we     <= 1'b0;
      ew_tag_error   <= 1'b0;
      tag_sync_error <= 1'b0;
      ew_fifo_data   <= '0;
      ew_size        <= '0;
      ew_tag         <= '0;
      src_axi_start  <= '0;
      switch_pending <= 1'b0;
      ew_timeout     <= 1'b0;
      sel_error      <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      active_sel     <= next_sel;
      curr_ewfifo_wr <= mux_curr_wr;
      ew_done        <= mux_done;
      ew_ovfl        <= mux_ovfl;
      ew_fifo_we     <= mux_we;
      ew_tag_error   <= mux_tag_error;
      tag_sync_error <= mux_sync_error;
      ew_fifo_data   <= mux_data;
      ew_size        <= mux_size;
      ew_tag         <= mux_tag;
      src_axi_start  <= start_vec;
      switch_pending <= req_valid && (req_sel != next_sel);
      ew_timeout     <= timeout_next;
      sel_error      <= sel_error | ~req_valid;
    end
  end

  assign window_open = (state == BUSY);

endmodule

// File: tb/tb_ew_source_switch.sv
// Directed bench for ew_source_switch: 4 sources, 3-bit select, 8-cycle watchdog.
module tb_ew_source_switch;

  localparam int NSRC = 4;
  localparam int SB   = 3;
  localparam int DB   = 32;
  localparam int EB   = 10;
  localparam int TB_  = 20;

  logic              serdesclk = 1'b0;
  logic              reset_serdesclk;
  logic [SB-1:0]     req_sel;
  logic [NSRC-1:0]   src_curr_ewfifo_wr, src_ew_done, src_ew_ovfl, src_ew_fifo_we;
  logic [NSRC-1:0]   src_ew_tag_error, src_tag_sync_error;
  logic [NSRC*DB-1:0]  src_ew_fifo_data;
  logic [NSRC*EB-1:0]  src_ew_size;
  logic [NSRC*TB_-1:0] src_ew_tag;
  logic              axi_start_on_serdesclk;
  logic              curr_ewfifo_wr, ew_done, ew_ovfl, ew_fifo_we, ew_tag_error, tag_sync_error;
  logic [DB-1:0]     ew_fifo_data;
  logic [EB-1:0]     ew_size;
  logic [TB_-1:0]    ew_tag;
  logic [NSRC-1:0]   src_axi_start;
  logic [SB-1:0]     active_sel;
  logic              window_open, switch_pending, ew_timeout, sel_error;

  int total = 0;
  int bad   = 0;

  ew_source_switch #(
    .NSRC(NSRC), .SEL_BITS(SB), .DIGI_BITS(DB), .EVENT_SIZE_BITS(EB),
    .SPILL_TAG_BITS(TB_), .DEFAULT_SEL(0), .TIMEOUT_CYCLES(8)
  ) dut (
    .serdesclk(serdesclk), .reset_serdesclk(reset_serdesclk), .req_sel(req_sel),
    .src_curr_ewfifo_wr(src_curr_ewfifo_wr), .src_ew_done(src_ew_done),
    .src_ew_ovfl(src_ew_ovfl), .src_ew_fifo_we(src_ew_fifo_we),
    .src_ew_tag_error(src_ew_tag_error), .src_tag_sync_error(src_tag_sync_error),
    .src_ew_fifo_data(src_ew_fifo_data), .src_ew_size(src_ew_size), .src_ew_tag(src_ew_tag),
    .axi_start_on_serdesclk(axi_start_on_serdesclk),
    .curr_ewfifo_wr(curr_ewfifo_wr), .ew_done(ew_done), .ew_ovfl(ew_ovfl),
    .ew_fifo_we(ew_fifo_we), .ew_tag_error(ew_tag_error), .tag_sync_error(tag_sync_error),
    .ew_fifo_data(ew_fifo_data), .ew_size(ew_size), .ew_tag(ew_tag),
    .src_axi_start(src_axi_start), .active_sel(active_sel), .window_open(window_open),
    .switch_pending(switch_pending), .ew_timeout(ew_timeout), .sel_error(sel_error)
  );

  always #5 serdesclk = ~serdesclk;

  // Source i carries tag 0x12345 + i*0x11111, data 0xD000000i, size i*100+7.
  function automatic logic [TB_-1:0] tag_of(int i);
    return TB_'(32'h12345 + i * 32'h11111);
  endfunction

  task automatic tick();
    @(posedge serdesclk);
    #1;
  endtask

  task automatic clear_flags();
    src_curr_ewfifo_wr = '0; src_ew_done = '0; src_ew_ovfl = '0;
    src_ew_fifo_we = '0; src_ew_tag_error = '0; src_tag_sync_error = '0;
  endtask

  task automatic test_reset();
    reset_serdesclk = 1'b1;
    req_sel = '0;
    axi_start_on_serdesclk = 1'b1;
    src_curr_ewfifo_wr = '1; src_ew_done = '1; src_ew_ovfl = '1;
    src_ew_fifo_we = '1; src_ew_tag_error = '1; src_tag_sync_error = '1;
    for (int i = 0; i < NSRC; i++) begin
      src_ew_fifo_data[i*DB +: DB]  = 32'hD000_0000 | i;
      src_ew_size[i*EB +: EB]       = EB'(i * 100 + 7);
      src_ew_tag[i*TB_ +: TB_]      = tag_of(i);
    end
    tick(); tick();
    total++;
    if ({curr_ewfifo_wr, ew_done, ew_ovfl, ew_fifo_we, ew_tag_error, tag_sync_error} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000",
        {curr_ewfifo_wr, ew_done, ew_ovfl, ew_fifo_we, ew_tag_error, tag_sync_error});
    end
    total++;
    if ({ew_tag, ew_size, ew_fifo_data} !== '0) begin
      bad++; $display("FAIL reset_data got tag=%h size=%h data=%h exp 0", ew_tag, ew_size, ew_fifo_data);
    end
    total++;
    if ({src_axi_start, active_sel, window_open, switch_pending, ew_timeout, sel_error} !== '0) begin
      bad++; $display("FAIL reset_ctrl got start=%b sel=%0d wo=%b sp=%b to=%b se=%b exp all 0",
        src_axi_start, active_sel, window_open, switch_pending, ew_timeout, sel_error);
    end
    reset_serdesclk = 1'b0;
    axi_start_on_serdesclk = 1'b0;
    clear_flags();
    tick();
    total++;
    if (ew_tag !== 20'h12345) begin
      bad++; $display("FAIL first_tag got=%h exp=12345", ew_tag);
    end
    total++;
    if (active_sel !== 3'd0 || ew_done !== 1'b0 || ew_fifo_we !== 1'b0 || window_open !== 1'b0) begin
      bad++; $display("FAIL first_state got sel=%0d done=%b we=%b wo=%b exp 0/0/0/0",
        active_sel, ew_done, ew_fifo_we, window_open);
    end
  endtask

  task automatic test_switch_mid_window();
    req_sel = 3'd0;
    axi_start_on_serdesclk = 1'b1;
    tick();
    total++;
    if (window_open !== 1'b1 || src_axi_start !== 4'b0001) begin
      bad++; $display("FAIL open_src0 got wo=%b start=%b exp 1/0001", window_open, src_axi_start);
    end
    axi_start_on_serdesclk = 1'b0;
    req_sel = 3'd2;
    src_ew_fifo_we = 4'b0100;
    tick();
    total++;
    if (active_sel !== 3'd0 || switch_pending !== 1'b1 || ew_tag !== tag_of(0) || ew_fifo_we !== 1'b0) begin
      bad++; $display("FAIL hold_src0 got sel=%0d sp=%b tag=%h we=%b exp 0/1/%h/0",
        active_sel, switch_pending, ew_tag, ew_fifo_we, tag_of(0));
    end
    src_ew_fifo_we = '0;
    src_ew_done = 4'b0001;
    tick();
    total++;
    if (ew_done !== 1'b1 || window_open !== 1'b0 || active_sel !== 3'd0) begin
      bad++; $display("FAIL close_src0 got done=%b wo=%b sel=%0d exp 1/0/0", ew_done, window_open, active_sel);
    end
    src_ew_done = '0;
    tick();
    total++;
    if (active_sel !== 3'd2 || switch_pending !== 1'b0) begin
      bad++; $display("FAIL switch_to2 got sel=%0d sp=%b exp 2/0", active_sel, switch_pending);
    end
    total++;
    if (ew_tag !== tag_of(2) || ew_fifo_data !== 32'hD000_0002 || ew_size !== 10'd207) begin
      bad++; $display("FAIL data_src2 got tag=%h data=%h size=%0d exp %h/D0000002/207",
        ew_tag, ew_fifo_data, ew_size, tag_of(2));
    end
  endtask

  task automatic test_start_steer();
    req_sel = 3'd3;
    axi_start_on_serdesclk = 1'b1;
    tick();
    total++;
    if (src_axi_start !== 4'b1000 || window_open !== 1'b1 || active_sel !== 3'd3) begin
      bad++; $display("FAIL steer3 got start=%b wo=%b sel=%0d exp 1000/1/3", src_axi_start, window_open, active_sel);
    end
    axi_start_on_serdesclk = 1'b0;
    tick();
    total++;
    if (src_axi_start !== 4'b0000) begin
      bad++; $display("FAIL steer_clear got=%b exp=0000", src_axi_start);
    end
    src_ew_done = 4'b1000;
    tick();
    src_ew_done = '0;
    req_sel = 3'd0;
    tick();
  endtask

  task automatic test_foreign_done();
    axi_start_on_serdesclk = 1'b1;
    tick();
    axi_start_on_serdesclk = 1'b0;
    src_ew_done = 4'b0010;
    tick();
    total++;
    if (ew_done !== 1'b0 || window_open !== 1'b1 || active_sel !== 3'd0) begin
      bad++; $display("FAIL foreign_done got done=%b wo=%b sel=%0d exp 0/1/0", ew_done, window_open, active_sel);
    end
    src_ew_done = 4'b0001;
    tick();
    total++;
    if (ew_done !== 1'b1 || window_open !== 1'b0) begin
      bad++; $display("FAIL own_done got done=%b wo=%b exp 1/0", ew_done, window_open);
    end
    src_ew_done = '0;
    tick();
  endtask

  task automatic test_timeout();
    axi_start_on_serdesclk = 1'b1;
    tick();
    axi_start_on_serdesclk = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      total++;
      if (ew_timeout !== 1'b0 || window_open !== 1'b1) begin
        bad++; $display("FAIL timeout_early cyc=%0d got to=%b wo=%b exp 0/1", j, ew_timeout, window_open);
      end
    end
    tick();
    total++;
    if (ew_timeout !== 1'b1 || window_open !== 1'b0) begin
      bad++; $display("FAIL timeout_fire got to=%b wo=%b exp 1/0", ew_timeout, window_open);
    end
    tick();
    total++;
    if (ew_timeout !== 1'b0 || window_open !== 1'b0) begin
      bad++; $display("FAIL timeout_pulse got to=%b wo=%b exp 0/0", ew_timeout, window_open);
    end
  endtask

  task automatic test_back_to_back();
    axi_start_on_serdesclk = 1'b1;
    tick();
    for (int j = 0; j < 5; j++) tick();
    src_ew_done = 4'b0001;
    tick();
    total++;
    if (window_open !== 1'b1 || src_axi_start !== 4'b0001 || ew_done !== 1'b1) begin
      bad++; $display("FAIL start_and_done got wo=%b start=%b done=%b exp 1/0001/1",
        window_open, src_axi_start, ew_done);
    end
    axi_start_on_serdesclk = 1'b0;
    src_ew_done = '0;
    for (int j = 1; j <= 7; j++) tick();
    total++;
    if (ew_timeout !== 1'b0 || window_open !== 1'b1) begin
      bad++; $display("FAIL restart_cnt got to=%b wo=%b exp 0/1", ew_timeout, window_open);
    end
    tick();
    total++;
    if (ew_timeout !== 1'b1 || window_open !== 1'b0) begin
      bad++; $display("FAIL restart_timeout got to=%b wo=%b exp 1/0", ew_timeout, window_open);
    end
  endtask

  task automatic test_sel_error_and_reset();
    req_sel = 3'd5;
    tick();
    total++;
    if (sel_error !== 1'b1 || active_sel !== 3'd0 || switch_pending !== 1'b0) begin
      bad++; $display("FAIL sel_error got se=%b sel=%0d sp=%b exp 1/0/0", sel_error, active_sel, switch_pending);
    end
    req_sel = 3'd1;
    tick();
    total++;
    if (sel_error !== 1'b1 || active_sel !== 3'd1 || ew_tag !== tag_of(1)) begin
      bad++; $display("FAIL sel_sticky got se=%b sel=%0d tag=%h exp 1/1/%h", sel_error, active_sel, ew_tag, tag_of(1));
    end
    axi_start_on_serdesclk = 1'b1;
    tick();
    src_ew_fifo_we = 4'b0010;
    src_ew_done = 4'b0010;
    reset_serdesclk = 1'b1;
    tick();
    total++;
    if ({window_open, sel_error, src_axi_start, ew_fifo_we, ew_done, ew_tag} !== '0 || active_sel !== 3'd0) begin
      bad++; $display("FAIL mid_reset got wo=%b se=%b start=%b we=%b done=%b tag=%h sel=%0d exp all 0",
        window_open, sel_error, src_axi_start, ew_fifo_we, ew_done, ew_tag, active_sel);
    end
    reset_serdesclk = 1'b0;
    axi_start_on_serdesclk = 1'b0;
    clear_flags();
    req_sel = 3'd0;
    tick();
    total++;
    if (window_open !== 1'b0 || sel_error !== 1'b0 || ew_tag !== tag_of(0)) begin
      bad++; $display("FAIL post_reset got wo=%b se=%b tag=%h exp 0/0/%h", window_open, sel_error, ew_tag, tag_of(0));
    end
  endtask

  initial begin
    test_reset();
    test_switch_mid_window();
    test_start_steer();
    test_foreign_done();
    test_timeout();
    test_back_to_back();
    test_sel_error_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ew_source_switch.md
# ew_source_switch

Registered N-way source selector between the event-window producers (DIGI readout channels, pattern generators, future emulators) and the EW_FIFO_controller, all on serdesclk. It generalises the two-way DIGI/pattern switch to NSRC sources. A source change is applied only between event windows, so no window is ever split across two sources. `axi_start_on_serdesclk` is steered to the selected source only, and a watchdog closes windows that never receive `ew_done`.

## Interface
- NSRC, 4: number of sources; 2..16.
- SEL_BITS, 2: width of select; ≥ clog2(NSRC).
- DIGI_BITS, 32: event-window data width.
- EVENT_SIZE_BITS, 10: `ew_size` width, in 64-bit beats.
- SPILL_TAG_BITS, 20: `ew_tag` width.
- DEFAULT_SEL, 0: `active_sel` after reset; 0 is DIGI.
- TIMEOUT_CYCLES, 65535: window watchdog limit; ≥ 2.

Ports:
- serdesclk  in  1  150 MHz clock; the only clock.
- reset_serdesclk  in  1  synchronous, active-high reset.
- req_sel  in  SEL_BITS  requested source.
- src_curr_ewfifo_wr, src_ew_done, src_ew_ovfl, src_ew_fifo_we, src_ew_tag_error, src_tag_sync_error  in  NSRC each  per-source flags; bit i belongs to source i.
- src_ew_fifo_data  in  NSRC*DIGI_BITS  source i at [i*DIGI_BITS +: DIGI_BITS].
- src_ew_size  in  NSRC*EVENT_SIZE_BITS  packed the same way.
- src_ew_tag  in  NSRC*SPILL_TAG_BITS  packed the same way.
- axi_start_on_serdesclk  in  1  window-start strobe.
- curr_ewfifo_wr, ew_done, ew_ovfl, ew_fifo_we, ew_tag_error, tag_sync_error  out  1 each  selected source, registered.
- ew_fifo_data, ew_size, ew_tag  out  DIGI_BITS / EVENT_SIZE_BITS / SPILL_TAG_BITS  selected source, registered.
- src_axi_start  out  NSRC  start strobe steered to one source.
- active_sel  out  SEL_BITS  source currently in effect.
- window_open  out  1  high in the BUSY state.
- switch_pending  out  1  `req_sel` is valid and differs from `active_sel`.
- ew_timeout  out  1  one-cycle pulse when the watchdog expires.
- sel_error  out  1  sticky flag: an out-of-range `req_sel` (≥ NSRC) was seen.

## Operation
- FSM has two states: IDLE and BUSY. Reset enters IDLE.
- next_sel:
  - IDLE with `req_sel` < NSRC: next_sel = `req_sel`.
  - Otherwise: next_sel = `active_sel`.
  - `active_sel` <= next_sel every cycle.
- Every mux selection in a cycle uses next_sel. This covers the data path, `src_axi_start` steering, and the `ew_done` used by the FSM.
- Data path: every output <= source[next_sel] every cycle. Signals from non-selected sources are ignored entirely.
- Start steering: `src_axi_start` <= `axi_start_on_serdesclk` ? (1 << next_sel) : 0.
- IDLE:
  - On `axi_start_on_serdesclk`: go to BUSY and clear the watchdog counter.
  - `src_ew_done[next_sel]` in IDLE is passed through with no state change.
- BUSY:
  - `src_ew_done[active_sel]` without a start: go to IDLE.
  - Start without done: stay in BUSY; the start is forwarded and the counter is cleared.
  - Start and done in the same cycle: stay in BUSY, clear the counter, no switch.
  - Counter reaches TIMEOUT_CYCLES-1 with no done and no start: `ew_timeout` = 1 next cycle, go to IDLE.
- `req_sel` ≥ NSRC: ignored for selection; `sel_error` <= 1 and holds until reset.
- `switch_pending` = (`req_sel` < NSRC) && (`req_sel` != `active_sel`). It is registered and may stay high through a whole window.
- Watchdog counter: width clog2(TIMEOUT_CYCLES); it never wraps and is held at 0 in IDLE.

## Timing
- Data and flag latency is 1 cycle: input at edge k, output valid after edge k+1.
- `src_axi_start` latency is 1 cycle.
- A switch takes effect on the first IDLE cycle. Data from the new source appears 1 cycle later.
- `ew_done` that closes a window is output 1 cycle later. The next cycle is already IDLE, so a new `req_sel` applies there.
- Reset (synchronous, including mid-window):
  - All outputs become 0, except `active_sel` = DEFAULT_SEL.
  - State goes to IDLE; counter and `sel_error` clear.
  - Inputs present during reset are not forwarded.

## Test plan
- Reset, `req_sel`=0, DIGI tag 0x12345 on source 0 -> 1 cycle later `ew_tag`=0x12345, `active_sel`=0, all flags 0.
- Open window on source 0, set `req_sel`=2 mid-window -> outputs stay on source 0 and `switch_pending`=1. `ew_done` from source 0 -> next cycle `active_sel`=2, `switch_pending`=0, then source 2 data appears.
- `req_sel`=3 and `axi_start` in the same IDLE cycle -> `src_axi_start`=4'b1000, `window_open`=1.
- `ew_done` pulse on source 1 while source 0 is active in BUSY -> `ew_done` output stays 0, FSM stays in BUSY.
- TIMEOUT_CYCLES=8, start with no done -> `ew_timeout` pulses once, 8 cycles after the start was registered; `window_open`=0 afterwards.
- `req_sel`=5 with NSRC=4 -> `sel_error`=1 and sticky, `active_sel` unchanged. Reset mid-window -> all outputs 0, `active_sel`=DEFAULT_SEL.
